// File: rtl/rv2t_pkg.sv
// Shared constants and types for the RV2T integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv2t_pkg;

  localparam int XLEN_DEF          = 32;
  localparam int REG_ADDR_BITS_DEF = 5;

  // Register that reads as zero when the hard-wired zero option is enabled.
  localparam int ZERO_ADDR = 0;

  // Controller state: CLEAR zeroes every bank after reset, RUN serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Latency: 1 cycle read; read-during-write to the same address returns the old data.
// Backpressure: none, accepts one read and one write every cycle.
//
// Ports:
//   clk              rising-edge clock
//   wr_en/addr/data  write port
//   rd_en/addr       read request, address sampled on the edge
//   rd_data          registered read data (holds when rd_en is low)
module dual_port_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset on the array or the read register so this maps onto block RAM.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rv2t_reg_file_mp.sv
// Multi-read-port integer register file: one RAM bank per read port, shared write, zero-clear after reset.
// Latency: 1 cycle read; writes are visible to a read issued on the same edge (write-first bypass).
// Backpressure: none in RUN; while ready is low (clear sequence) reads and writes are dropped.
//
// Ports:
//   clk, sync_reset      clock and synchronous active-high reset
//   ready                high once every bank has been zeroed
//   read_enable          read request for all ports
//   read_addr            port p address at [p*ADDR_BITS +: ADDR_BITS]
//   read_en_out          read_enable delayed one cycle, qualified by ready
//   read_data_out        port p data at [p*XLEN +: XLEN], valid while read_en_out is high
//   write_enable/addr    shared write port applied to every bank
//   write_data_in        write data
module rv2t_reg_file_mp
  import rv2t_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ADDR_BITS = REG_ADDR_BITS_DEF,
  parameter int NUM_RD    = 2,
  parameter bit ZERO_REG  = 1'b1
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  output logic                        ready,
  input  logic                        read_enable,
  input  logic [NUM_RD*ADDR_BITS-1:0] read_addr,
  output logic                        read_en_out,
  output logic [NUM_RD*XLEN-1:0]      read_data_out,
  input  logic                        write_enable,
  input  logic [ADDR_BITS-1:0]        write_addr,
  input  logic [XLEN-1:0]             write_data_in
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_BITS-1:0] ZADDR     = ADDR_BITS'(ZERO_ADDR);

  // ---------------------------------------------------------------------------
  // Controller: walks clr_cnt over every address once, then enters RUN.
  // ---------------------------------------------------------------------------
  rf_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end
  end

  logic run;
  assign run   = (state_q == RUN);
  assign ready = run;

  // ---------------------------------------------------------------------------
  // Bank write port: clear writes while in CLEAR, external writes in RUN.
  // ---------------------------------------------------------------------------
  logic                 zero_suppress;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [XLEN-1:0]      ram_wdata;

  assign zero_suppress = ZERO_REG && (write_addr == ZADDR);

  always_comb begin
    ram_we    = 1'b1;
    ram_waddr = clr_cnt_q;
    ram_wdata = '0;
    if (run) begin
      ram_we    = write_enable & ~zero_suppress;
      ram_waddr = write_addr;
      ram_wdata = write_data_in;
    end
  end

  // Reads are only accepted in RUN; anything requested during CLEAR is dropped.
  logic rd_accept;
  assign rd_accept = run & read_enable;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      read_en_out <= 1'b0;
    end else begin
      read_en_out <= rd_accept;
    end
  end

  // Write data captured alongside each accepted read; shared by all ports'
  // bypass paths since there is only one write port.
  logic [XLEN-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      wdata_q <= write_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port bank, bypass record and output mux.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_BITS-1:0] port_addr;
    logic [ADDR_BITS-1:0] raddr_q;
    logic                 wr_hit_q;
    logic [XLEN-1:0]      bram_data;

    assign port_addr = read_addr[p*ADDR_BITS +: ADDR_BITS];

    dual_port_ram #(
      .DATA_W (XLEN),
      .ADDR_W (ADDR_BITS)
    ) u_bank (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_en   (rd_accept),
      .rd_addr (port_addr),
      .rd_data (bram_data)
    );

    // The RAM returns old data on a same-address collision, so remember
    // whether this read collided with the concurrent write.
    always_ff @(posedge clk) begin
      if (rd_accept) begin
        raddr_q  <= port_addr;
        wr_hit_q <= write_enable & (write_addr == port_addr);
      end
    end

    // Zero register outranks the bypass so a discarded x0 write never leaks.
    assign read_data_out[p*XLEN +: XLEN] =
        (ZERO_REG && (raddr_q == ZADDR)) ? '0 :
        wr_hit_q                         ? wdata_q :
                                           bram_data;
  end

endmodule
